osd_diag_event_arbiter: RTL and testbench

OSD_DIAG_EVENT_ARBITER -- requirements
Module: osd_diag_event_arbiter

---
 rtl/osd_diag_event_arbiter.sv | 159 +++++++++++++++
 tb/tb_osd_diag_event_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_diag_event_arbiter.sv
// Round-robin packet arbiter merging NUM_SRC diagnosis event flit streams onto one dii link.
// Packets longer than MAX_PKT_LEN are cut at the limit and the remainder is drained.
module osd_diag_event_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         en_mask,
    input  logic [NUM_SRC-1:0]         in_valid,
    input  logic [NUM_SRC-1:0]         in_last,
    input  logic [16*NUM_SRC-1:0]      in_data,
    output logic [NUM_SRC-1:0]         in_ready,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [15:0]                out_data,
    input  logic                       out_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [7:0]                 trunc_cnt
);

    localparam int GW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [GW-1:0]   grant_r;
    logic [GW-1:0]   pick_s;
    logic            found_s;
    logic [NUM_SRC-1:0] req_s;
    logic            g_valid_s;
    logic            g_last_s;
    logic [15:0]     g_data_s;
    logic            at_limit_s;
    logic            xfer_s;
    logic [7:0]      cnt_r;
    logic [7:0]      trunc_r;
    logic            busy_r;

    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int step);
        int sum;
        sum = (int'(base) + step) % NUM_SRC;
        return GW'(sum);
    endfunction

    assign req_s      = in_valid & en_mask;
    assign at_limit_s = (cnt_r == 8'(MAX_PKT_LEN - 1));
    assign xfer_s     = (state_r == PASS) & g_valid_s & out_ready;

    // Rotating search: walk from farthest to nearest so the first requester after grant_r wins.
    always_comb begin
        pick_s  = grant_r;
        found_s = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            pick_s  = req_s[rr_index(grant_r, k)] ? rr_index(grant_r, k) : pick_s;
            found_s = found_s | req_s[rr_index(grant_r, k)];
        end
    end

    // Select the handshake signals of the locked source.
    always_comb begin
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_data_s  = 16'h0000;
        for (int i = 0; i < NUM_SRC; i++) begin
            g_valid_s = (grant_r == GW'(i)) ? in_valid[i]          : g_valid_s;
            g_last_s  = (grant_r == GW'(i)) ? in_last[i]           : g_last_s;
            g_data_s  = (grant_r == GW'(i)) ? in_data[16*i +: 16] : g_data_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) next_state_s = PASS;
                else         next_state_s = IDLE;
            end
            PASS: begin
                if (xfer_s && g_last_s)        next_state_s = IDLE;
                else if (xfer_s && at_limit_s) next_state_s = DRAIN;
                else                           next_state_s = PASS;
            end
            DRAIN: begin
                if (g_valid_s && g_last_s) next_state_s = IDLE;
                else                       next_state_s = DRAIN;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output logic: PASS forwards the granted source combinationally, DRAIN swallows its flits.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 16'h0000;
        in_ready  = '0;
        case (state_r)
            PASS: begin
                out_valid = g_valid_s;
                out_last  = g_last_s | at_limit_s;
                out_data  = g_data_s;
                for (int i = 0; i < NUM_SRC; i++) begin
                    in_ready[i] = (grant_r == GW'(i)) ? out_ready : 1'b0;
                end
            end
            DRAIN: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    in_ready[i] = (grant_r == GW'(i));
                end
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // Grant pointer, flit counter, truncation counter and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r <= GW'(NUM_SRC - 1);
            cnt_r   <= 8'd0;
            trunc_r <= 8'd0;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            if ((state_r == IDLE) && found_s) begin
                grant_r <= pick_s;
                cnt_r   <= 8'd0;
            end else if (xfer_s) begin
                cnt_r <= cnt_r + 8'd1;
            end
            if (xfer_s && at_limit_s && !g_last_s && (trunc_r != 8'hFF)) begin
                trunc_r <= trunc_r + 8'd1;
            end
        end
    end

    assign grant_id  = grant_r;
    assign busy      = busy_r;
    assign trunc_cnt = trunc_r;

endmodule

// File: tb/tb_osd_diag_event_arbiter.sv
// Randomized bench for osd_diag_event_arbiter against a cycle-level packet model,
// plus directed scenarios for single packets, fairness, masking, truncation, stalls and reset.
module tb_osd_diag_event_arbiter;

    localparam int N    = 4;
    localparam int MAXL = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    en_mask  = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_last  = '0;
    logic [16*N-1:0] in_data  = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid, out_last;
    logic [15:0]     out_data;
    logic            out_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic [7:0]      trunc_cnt;

    osd_diag_event_arbiter #(.NUM_SRC(N), .MAX_PKT_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last),
        .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id), .busy(busy),
        .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // source stimulus state (len_cfg 0 = random length per packet)
    int len_cfg[N], pkts_left[N], rem[N], seq[N];
    int vprob, rprob, force_ready;
    bit rand_mask;
    logic [N-1:0] mask_cfg;

    // reference model state
    bit m_busy, m_drain;
    int m_g, m_cnt, m_trunc;
    logic e_ov, e_ol;
    logic [15:0] e_od;
    logic [N-1:0] e_ir;

    // observations of the DUT for directed scenarios
    int grant_log[$];
    int pkt_log[$];
    int obs_flits, drained_obs;
    bit prev_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        pkt_log.delete();
        obs_flits   = 0;
        drained_obs = 0;
    endtask

    task automatic setup(input int len, input int pk, input logic [N-1:0] who);
        for (int i = 0; i < N; i++) begin
            if (who[i]) begin
                len_cfg[i]   = len;
                pkts_left[i] = pk;
            end
        end
    endtask

    function automatic bit all_done();
        bit d = !m_busy;
        for (int i = 0; i < N; i++) d = d && (rem[i] == 0) && (pkts_left[i] == 0);
        return d;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && pkts_left[i] > 0) begin
                rem[i] = (len_cfg[i] == 0) ? int'($urandom_range(12, 1)) : len_cfg[i];
                pkts_left[i]--;
            end
            in_valid[i] = (rem[i] > 0) && ($urandom_range(99) < vprob);
            in_last[i]  = (rem[i] == 1);
            in_data[16*i +: 16] = {4'(i), 12'(seq[i])};
        end
        out_ready = (force_ready >= 0) ? force_ready[0] : ($urandom_range(99) < rprob);
        en_mask   = rand_mask ? N'($urandom) : mask_cfg;
    endtask

    task automatic eval_and_check();
        e_ov = 1'b0; e_ol = 1'b0; e_od = 16'h0; e_ir = '0;
        if (m_busy && m_drain) begin
            e_ir[m_g] = 1'b1;
        end else if (m_busy) begin
            e_ov = in_valid[m_g];
            e_od = in_data[16*m_g +: 16];
            e_ol = in_last[m_g] || (m_cnt == MAXL - 1);
            e_ir[m_g] = out_ready;
        end
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, m_g);
        chk("trunc_cnt", trunc_cnt, m_trunc);
        chk("out_valid", out_valid, e_ov);
        chk("in_ready", in_ready, e_ir);
        if (e_ov) begin
            chk("out_last", out_last, e_ol);
            chk("out_data", out_data, e_od);
        end
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        if (out_valid && out_ready) begin
            obs_flits++;
            if (out_last) begin
                pkt_log.push_back(obs_flits);
                obs_flits = 0;
            end
        end
        if (busy && !out_valid && ((in_ready & in_valid) != '0)) drained_obs++;
    endtask

    task automatic advance();
        logic [N-1:0] req;
        for (int i = 0; i < N; i++) begin
            if (e_ir[i] && in_valid[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
        if (!m_busy) begin
            req = in_valid & en_mask;
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req[(m_g + k) % N]) begin
                        m_g = (m_g + k) % N;
                        break;
                    end
                end
                m_busy = 1'b1; m_drain = 1'b0; m_cnt = 0;
            end
        end else if (m_drain) begin
            if (in_valid[m_g] && in_last[m_g]) m_busy = 1'b0;
        end else if (in_valid[m_g] && out_ready) begin
            if (in_last[m_g]) begin
                m_busy = 1'b0;
            end else if (m_cnt == MAXL - 1) begin
                m_drain = 1'b1;
                if (m_trunc < 255) m_trunc++;
            end
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        drive();
        #4;
        eval_and_check();
        advance();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (n < budget && !all_done()) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, (n < budget), 1'b1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; pkts_left[i] = 0; seq[i] = 0; len_cfg[i] = 0;
        end
        in_valid = '0;
        m_busy = 1'b0; m_drain = 1'b0; m_g = N - 1; m_cnt = 0; m_trunc = 0;
        #1;
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, '0);
        chk({tag, "_grant_id"}, grant_id, N - 1);
        chk({tag, "_trunc_cnt"}, trunc_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        prev_busy = 1'b0;
        rand_mask = 1'b0; mask_cfg = 4'hF; vprob = 100; rprob = 100; force_ready = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        #2;
        do_reset("por");

        // single 3-flit packet from source 2
        clear_logs();
        setup(3, 1, 4'b0100);
        run_until_done("single", 50);
        chk("single_grants", grant_log.size(), 1);
        chk("single_grant_id", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
        chk("single_len", (pkt_log.size() > 0) ? pkt_log[0] : -1, 3);
        chk("single_hold_grant", grant_id, 2'd2);

        // all sources, continuous 2-flit packets
        do_reset("rr");
        clear_logs();
        setup(2, 5, 4'hF);
        run_until_done("rr", 300);
        chk("rr_grants", grant_log.size(), 20);
        for (int k = 0; k < grant_log.size() && k < 20; k++) chk("rr_order", grant_log[k], k % 4);
        for (int k = 0; k < pkt_log.size(); k++) chk("rr_pkt_len", pkt_log[k], 2);

        // 11-flit packet truncated to 8
        do_reset("trunc");
        clear_logs();
        setup(11, 1, 4'b0010);
        run_until_done("trunc", 60);
        chk("trunc_pkts", pkt_log.size(), 1);
        chk("trunc_len", (pkt_log.size() > 0) ? pkt_log[0] : -1, 8);
        chk("trunc_drained", drained_obs, 3);
        chk("trunc_count", trunc_cnt, 8'd1);

        // mask 0101 with every source requesting
        do_reset("mask");
        clear_logs();
        mask_cfg = 4'b0101;
        setup(2, 100, 4'hF);
        for (int c = 0; c < 60; c++) cycle();
        chk("mask_enough_grants", (grant_log.size() >= 10), 1'b1);
        for (int k = 0; k < grant_log.size(); k++) chk("mask_order", grant_log[k], (k % 2) * 2);

        // out_ready stall of 5 cycles mid-packet
        do_reset("stall");
        clear_logs();
        setup(10, 1, 4'b1000);
        n = 0;
        while (n < 20 && !(m_busy && !m_drain && m_cnt == 2)) begin
            cycle();
            n++;
        end
        chk("stall_reached", (n < 20), 1'b1);
        force_ready = 0;
        for (int c = 0; c < 5; c++) begin
            drive();
            #4;
            eval_and_check();
            chk("stall_data", out_data, 16'h3002);
            chk("stall_ready", in_ready[3], 1'b0);
            advance();
        end
        force_ready = -1;
        run_until_done("stall", 40);
        chk("stall_len", (pkt_log.size() > 0) ? pkt_log[0] : -1, 8);

        // reset during the second flit
        do_reset("prep");
        clear_logs();
        setup(4, 1, 4'b0010);
        n = 0;
        while (n < 20 && !(m_busy && m_cnt == 1)) begin
            cycle();
            n++;
        end
        chk("midrst_reached", (n < 20), 1'b1);
        drive();
        #2;
        do_reset("midrst");
        chk("midrst_no_last", pkt_log.size(), 0);
        clear_logs();
        setup(2, 1, 4'hF);
        run_until_done("midrst", 60);
        chk("midrst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // truncation counter saturation
        do_reset("sat");
        clear_logs();
        setup(9, 70, 4'hF);
        run_until_done("sat", 4000);
        chk("sat_trunc", trunc_cnt, 8'd255);

        // random lengths, masks and handshakes
        do_reset("rand");
        clear_logs();
        rand_mask = 1'b1; vprob = 70; rprob = 70;
        setup(0, 30, 4'hF);
        run_until_done("rand", 20000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
